// File: rtl/gcd_req_master_if.sv
// ---------------------------------------------------------------------------
// gcd_req_master_if
//
// Bundles every non-clock/reset signal of the GCD request master: the operand
// source handshake, the engine req/busy/valid handshake and the status
// outputs. Signal names keep the _i/_o suffixes as seen from the master.
//
//   Source side   : op_valid_i, op_a_i, op_b_i  -> master
//                   op_ready_o                  <- master
//   Engine side   : req_o, a_o, b_o             <- master
//                   busy_i, valid_i, result_val_i -> master
//   Status        : result_val_o, result_valid_o, rej_cnt_o, idle_o <- master
//
// Modports:
//   master - used by gcd_req_master itself
//   slave  - used by whatever surrounds it (source + engine + observer)
// ---------------------------------------------------------------------------
interface gcd_req_master_if #(
  parameter int WIDTH = 8
);

  // Operand source handshake
  logic             op_valid_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             op_ready_o;

  // Engine request / result handshake
  logic             req_o;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             busy_i;
  logic             valid_i;
  logic [WIDTH-1:0] result_val_i;

  // Status / result outputs
  logic [WIDTH-1:0] result_val_o;
  logic             result_valid_o;
  logic [7:0]       rej_cnt_o;
  logic             idle_o;

  modport master (
    input  op_valid_i, op_a_i, op_b_i,
    input  busy_i, valid_i, result_val_i,
    output op_ready_o,
    output req_o, a_o, b_o,
    output result_val_o, result_valid_o, rej_cnt_o, idle_o
  );

  modport slave (
    output op_valid_i, op_a_i, op_b_i,
    output busy_i, valid_i, result_val_i,
    input  op_ready_o,
    input  req_o, a_o, b_o,
    input  result_val_o, result_valid_o, rej_cnt_o, idle_o
  );

endinterface : gcd_req_master_if

// File: rtl/gcd_req_master.sv
// ---------------------------------------------------------------------------
// gcd_req_master
//
// Queued request master for the GCD engine. Operand pairs from the source are
// buffered in a DEPTH-entry FIFO; pairs with a zero operand are consumed but
// dropped and counted. A three-state FSM pops one pair at a time, presents it
// to the engine with a req/busy handshake, then waits for the engine's
// valid_i strobe and captures the result.
//
// Parameters:
//   WIDTH - operand/result width in bits (>= 2)
//   DEPTH - FIFO entries, power of two, >= 2
//
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - gcd_req_master_if.master:
//     op_valid_i/op_a_i/op_b_i  operand pair from the source
//     op_ready_o                FIFO not full (pair taken on valid && ready)
//     req_o/a_o/b_o             request and operands to the engine
//     busy_i                    engine busy; request taken on req_o && !busy_i
//     valid_i/result_val_i      engine result strobe and value
//     result_val_o              last captured result
//     result_valid_o            one-cycle pulse when result_val_o updates
//     rej_cnt_o                 saturating count of zero-operand pairs
//     idle_o                    FSM idle and FIFO empty
// ---------------------------------------------------------------------------
module gcd_req_master #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  gcd_req_master_if.master     bus
);

  localparam int              AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   LP_PTR_ONE  = AW'(1);
  localparam logic [AW:0]     LP_CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]     LP_CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [7:0]      LP_REJ_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           r_state;
  logic             r_req;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_res_vld;
  logic [7:0]       r_rej_cnt;

  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // -------------------------------------------------------------------------
  // Intake / pop decode
  // -------------------------------------------------------------------------
  logic w_full;
  logic w_empty;
  logic w_take;
  logic w_nonzero;
  logic w_push;
  logic w_reject;
  logic w_pop;

  // Full/empty come only from the registered count, so op_ready_o never
  // depends on a same-cycle pop: a push into a full FIFO is always refused.
  assign w_full    = (r_count == LP_CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_take    = bus.op_valid_i && !w_full;
  assign w_nonzero = (bus.op_a_i != '0) && (bus.op_b_i != '0);
  assign w_push    = w_take && w_nonzero;
  assign w_reject  = w_take && !w_nonzero;

  // Pop only from the registered state, so a pair pushed into an empty FIFO
  // is popped one edge later, never on the edge it arrives.
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;

  // -------------------------------------------------------------------------
  // FIFO storage
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and count alone, which keeps the array mappable to plain RAM/flops
  // without a reset tree.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= bus.op_a_i;
      r_mem_b[r_wr_ptr] <= bus.op_b_i;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers, occupancy and reject counter
  // -------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments only, so all
  // registers see the pre-edge values of each other regardless of order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rej_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end

      // Push and pop together leave the occupancy unchanged.
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (w_reject && (r_rej_cnt != LP_REJ_MAX)) begin
        r_rej_cnt <= r_rej_cnt + 8'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
    end else begin
      r_res_vld <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_a     <= r_mem_a[r_rd_ptr];
            r_b     <= r_mem_b[r_rd_ptr];
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end

        // a_o/b_o stay put while the engine is busy; they also keep their
        // values after acceptance until the next pop.
        ST_REQ: begin
          if (!bus.busy_i) begin
            r_req   <= 1'b0;
            r_state <= ST_WAIT;
          end
        end

        // valid_i only matters here; strobes in IDLE/REQ fall through.
        ST_WAIT: begin
          if (bus.valid_i) begin
            r_res     <= bus.result_val_i;
            r_res_vld <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.op_ready_o     = !w_full;
  assign bus.req_o          = r_req;
  assign bus.a_o            = r_a;
  assign bus.b_o            = r_b;
  assign bus.result_val_o   = r_res;
  assign bus.result_valid_o = r_res_vld;
  assign bus.rej_cnt_o      = r_rej_cnt;
  assign bus.idle_o         = (r_state == ST_IDLE) && w_empty;

endmodule : gcd_req_master
